// File: rtl/axi_burst_reader_if.sv
// axi_burst_reader_if: command, AXI4 read channels and AXI-stream output of the burst reader
interface axi_burst_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] s_cmd_addr;
  logic [LEN_WIDTH-1:0]  s_cmd_len;
  logic                  s_cmd_valid;
  logic                  s_cmd_ready;
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  modport master (
    input  s_cmd_addr, s_cmd_len, s_cmd_valid,
    output s_cmd_ready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );
  modport slave (
    output s_cmd_addr, s_cmd_len, s_cmd_valid,
    input  s_cmd_ready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_burst_reader.sv
// axi_burst_reader: splits (address, beats) commands into 4 KB-safe AXI4 INCR bursts and streams the data out
module axi_burst_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst,
  axi_burst_reader_if.master  bus,
  output logic                busy,
  output logic                error
);
  localparam int SZ = $clog2(STRB_WIDTH);
  localparam int LW = LEN_WIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH:0] remaining, page_beats, lim, beats;
  logic [7:0] burst_cnt;
  logic [12:0] page_left;
  logic [DATA_WIDTH-1:0] tdata;
  logic tvalid, tlast, accept, ar_fire, r_fire, unused_rid;
  // bytes left before the next 4 KB boundary, turned into beats
  assign page_left  = 13'd4096 - {1'b0, addr_reg[11:0]};
  assign page_beats = LW'(page_left >> SZ);
  assign lim        = remaining < page_beats ? remaining : page_beats;
  assign beats      = lim < LW'(MAX_BURST_LEN) ? lim : LW'(MAX_BURST_LEN);
  assign bus.s_cmd_ready   = state == IDLE && !rst;
  assign bus.m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign bus.m_axi_araddr  = addr_reg;
  assign bus.m_axi_arlen   = 8'(beats - LW'(1));
  assign bus.m_axi_arsize  = 3'(SZ);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0011;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = state == ADDR;
  assign bus.m_axi_rready  = state == DATA && (!tvalid || bus.m_axis_tready);
  assign bus.m_axis_tdata  = tdata;
  assign bus.m_axis_tlast  = tlast;
  assign bus.m_axis_tvalid = tvalid;
  assign busy       = state != IDLE;
  assign accept     = bus.s_cmd_valid && bus.s_cmd_ready;
  assign ar_fire    = state == ADDR && bus.m_axi_arready;
  assign r_fire     = bus.m_axi_rvalid && bus.m_axi_rready;
  assign unused_rid = ^bus.m_axi_rid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      error  <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg  <= bus.s_cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
        remaining <= {1'b0, bus.s_cmd_len} + LW'(1);
        error     <= 1'b0;
        state     <= ADDR;
      end
      if (ar_fire) begin
        addr_reg  <= addr_reg + (ADDR_WIDTH'(beats) << SZ);
        remaining <= remaining - beats;
        burst_cnt <= 8'(beats - LW'(1));
        state     <= DATA;
      end
      // beat counting is internal; rlast is only cross-checked
      if (r_fire) begin
        tdata     <= bus.m_axi_rdata;
        tvalid    <= 1'b1;
        tlast     <= burst_cnt == 8'd0 && remaining == '0;
        burst_cnt <= burst_cnt - 8'd1;
        if (bus.m_axi_rresp != 2'b00 || bus.m_axi_rlast != (burst_cnt == 8'd0)) error <= 1'b1;
        if (burst_cnt == 8'd0) state <= remaining == '0 ? IDLE : ADDR;
      end else if (bus.m_axis_tready) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_reader.sv
// tb_axi_burst_reader: directed commands against a queue-based AXI slave and stream model
module tb_axi_burst_reader;
  typedef struct packed { logic [15:0] a; logic [7:0] l; } ar_t;
  logic clk = 1'b0, rst = 1'b1, busy, error;
  int nchk = 0, nfail = 0, cyc = 0;
  int sl_idx = 0, r_count = 0, err_at = -1, t_seen = 0, tlast_seen = 0;
  int ar_mode = 0, r_mode = 0, t_mode = 0;
  ar_t exp_ar[$], ar_log[$], sl_q[$];
  logic [32:0] exp_t[$];
  bit ar_f = 0, r_f = 0, t_f = 0, ar_wait = 0;
  ar_t ar_cur, ar_hold;
  logic [31:0] t_d;
  logic t_l;

  always #5 clk = ~clk;

  axi_burst_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .LEN_WIDTH(16)) bus ();
  axi_burst_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(0),
                     .MAX_BURST_LEN(16), .LEN_WIDTH(16))
    dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .error(error));

  function automatic logic [31:0] mem(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // expected bursts and beats straight from the command: split at 16 beats and 4 KB pages
  task automatic plan(input logic [15:0] addr, input int len);
    int a, rem, b;
    ar_t e;
    logic [15:0] x;
    a = int'(addr) & 32'hFFFC;
    rem = len + 1;
    for (int i = 0; i <= len; i++) begin
      x = 16'(a + 4 * i);
      exp_t.push_back({i == len, mem(x)});
    end
    while (rem > 0) begin
      b = rem;
      if (b > 16) b = 16;
      if (b > (4096 - a % 4096) / 4) b = (4096 - a % 4096) / 4;
      e.a = 16'(a);
      e.l = 8'(b - 1);
      exp_ar.push_back(e);
      a = (a + 4 * b) % 65536;
      rem -= b;
    end
  endtask

  // slave, sink and per-cycle comparison: handshakes latched just before each posedge, consumed at the next negedge
  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rid     = '0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_ar.delete(); exp_t.delete(); sl_q.delete();
        sl_idx = 0; r_count = 0; ar_wait = 0;
      end else begin
        if (ar_wait)
          check("ar_hold", 64'({bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen}), 64'({1'b1, ar_hold}));
        if (ar_f) begin
          if (exp_ar.size() == 0) check("ar_extra", 64'(ar_cur), 64'hFFFF_FFFF);
          else check("ar", 64'(ar_cur), 64'(exp_ar.pop_front()));
          ar_log.push_back(ar_cur);
          sl_q.push_back(ar_cur);
        end
        if (r_f && sl_q.size() > 0) begin
          r_count++;
          if (sl_idx == int'(sl_q[0].l)) begin
            void'(sl_q.pop_front());
            sl_idx = 0;
          end else sl_idx++;
        end
        if (t_f) begin
          t_seen++;
          if (t_l) tlast_seen++;
          if (exp_t.size() == 0) check("beat_extra", 64'({t_l, t_d}), 64'hFFFF_FFFF_FFFF);
          else check("beat", 64'({t_l, t_d}), 64'(exp_t.pop_front()));
        end
      end
      bus.m_axi_arready = ar_mode == 0 ? 1'b1 : (cyc % 3 == 0);
      if (sl_q.size() > 0 && (r_mode == 0 || cyc % 3 != 1)) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = mem(16'(int'(sl_q[0].a) + 4 * sl_idx));
        bus.m_axi_rlast  = sl_idx == int'(sl_q[0].l);
        bus.m_axi_rresp  = r_count == err_at ? 2'b10 : 2'b00;
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = '0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
      end
      bus.m_axis_tready = t_mode == 0 ? 1'b1 : t_mode == 1 ? cyc[0] : (cyc % 5 < 3);
      #1;
      ar_cur.a = bus.m_axi_araddr;
      ar_cur.l = bus.m_axi_arlen;
      ar_hold  = ar_cur;
      ar_f    = !rst && bus.m_axi_arvalid && bus.m_axi_arready;
      ar_wait = !rst && bus.m_axi_arvalid && !bus.m_axi_arready;
      r_f     = !rst && bus.m_axi_rvalid && bus.m_axi_rready;
      t_f     = !rst && bus.m_axis_tvalid && bus.m_axis_tready;
      t_d     = bus.m_axis_tdata;
      t_l     = bus.m_axis_tlast;
      if (!rst && bus.m_axi_rready && bus.m_axis_tvalid)
        check("rready_under_stall", 64'(bus.m_axis_tready), 64'd1);
    end
  end

  task automatic cmd(input logic [15:0] a, input int len);
    int n = 0;
    while (!bus.s_cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("cmd_ready_timeout", 64'd0, 64'd1);
    plan(a, len);
    bus.s_cmd_addr  = a;
    bus.s_cmd_len   = 16'(len);
    bus.s_cmd_valid = 1'b1;
    @(negedge clk);
    bus.s_cmd_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("arvalid_after_accept", 64'(bus.m_axi_arvalid), 64'd1);
    check("error_cleared_on_accept", 64'(error), 64'd0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_t.size() > 0 || exp_ar.size() > 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    check(name, 64'(n < 3000), 64'd1);
  endtask

  task automatic start_log();
    ar_log.delete();
    t_seen = 0;
    tlast_seen = 0;
  endtask

  initial begin
    int n;
    bus.s_cmd_valid = 1'b0;
    bus.s_cmd_addr  = '0;
    bus.s_cmd_len   = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.s_cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(bus.s_cmd_ready), 64'd1);
    check("ar_const", 64'({bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                            bus.m_axi_arcache, bus.m_axi_arprot}),
          64'({8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));

    start_log();
    cmd(16'h0000, 39);
    wait_done("t1_done");
    check("t1_ar_count", 64'(ar_log.size()), 64'd3);
    check("t1_ar0", 64'(ar_log[0]), 64'({16'h0000, 8'd15}));
    check("t1_ar1", 64'(ar_log[1]), 64'({16'h0040, 8'd15}));
    check("t1_ar2", 64'(ar_log[2]), 64'({16'h0080, 8'd7}));
    check("t1_beats", 64'(t_seen), 64'd40);
    check("t1_tlast_count", 64'(tlast_seen), 64'd1);
    check("t1_error", 64'(error), 64'd0);

    ar_mode = 1; r_mode = 1;
    start_log();
    cmd(16'h0FF0, 7);
    wait_done("t2_done");
    check("t2_ar_count", 64'(ar_log.size()), 64'd2);
    check("t2_ar0", 64'(ar_log[0]), 64'({16'h0FF0, 8'd3}));
    check("t2_ar1", 64'(ar_log[1]), 64'({16'h1000, 8'd3}));
    check("t2_beats", 64'(t_seen), 64'd8);

    ar_mode = 0; r_mode = 0;
    start_log();
    cmd(16'h0003, 0);
    wait_done("t3_done");
    check("t3_ar", 64'(ar_log[0]), 64'({16'h0000, 8'd0}));
    check("t3_beats", 64'(t_seen), 64'd1);
    check("t3_tlast", 64'(tlast_seen), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);

    t_mode = 1;
    start_log();
    cmd(16'h0200, 15);
    wait_done("t4_done");
    check("t4_beats", 64'(t_seen), 64'd16);
    check("t4_error", 64'(error), 64'd0);

    t_mode = 2; r_mode = 1;
    r_count = 0; err_at = 2;
    start_log();
    cmd(16'h0300, 7);
    wait_done("t5_done");
    err_at = -1;
    check("t5_beats", 64'(t_seen), 64'd8);
    check("t5_error_set", 64'(error), 64'd1);
    repeat (4) @(negedge clk);
    check("t5_error_sticky", 64'(error), 64'd1);
    cmd(16'h0400, 1);
    wait_done("t5b_done");
    check("t5b_error", 64'(error), 64'd0);

    t_mode = 0; r_mode = 0;
    start_log();
    cmd(16'h0500, 15);
    n = 0;
    while (t_seen < 5 && n < 500) begin @(negedge clk); n++; end
    check("t6_reach_data", 64'(n < 500), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("t6_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_cmd_ready_in_rst", 64'(bus.s_cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_cmd_ready_after", 64'(bus.s_cmd_ready), 64'd1);
    check("t6_tvalid_after", 64'(bus.m_axis_tvalid), 64'd0);
    start_log();
    cmd(16'h0600, 3);
    wait_done("t6_recover_done");
    check("t6_recover_beats", 64'(t_seen), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
